seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Parametrised, multi-cycle shift/rotate unit for the CPU datapath.
- Takes a WIDTH-bit operand, a 3-bit function select and a shift amount, then performs one 1-bit step per clock until AMT steps are done.
- Start/busy/done handshake lets the control unit stall while a multi-position shift runs.
- Carry out reports the last bit shifted or rotated out, so flag logic can use it directly.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
AMTW, 4, width of shift-amount port; AMT range 0..2^AMTW-1

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  request pulse; sampled only when idle (BUSY=0)
F  input  WIDTH  operand, captured on accepted START
CI  input  1  carry in, captured on accepted START
HSEL  input  3  function select, captured on accepted START
AMT  input  AMTW  number of 1-bit steps, captured on accepted START
S  output  WIDTH  result/working register
CO  output  1  carry out/working carry
BUSY  output  1  high while steps are in progress
DONE  output  1  one-cycle pulse when the result is final

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates on the CLK rising edge.
- Reset values: S=0, CO=0, BUSY=0, DONE=0, step counter=0, FSM=IDLE.
- RESET mid-operation aborts the operation: no DONE pulse, and all outputs return to reset values at that edge.
- FSM states: IDLE, RUN.
- IDLE to RUN on an edge with START=1, AMT!=0 and HSEL in {001,010,100,101,110,111}.
- RUN to IDLE on the edge that performs the final step.
- Accepted START at edge k, multi-step case:
  - S<=F; count<=AMT; BUSY<=1.
  - CO<=CI for HSEL 100/111, else CO<=0.
- Accepted START at edge k, single-cycle case (HSEL 000/011, or AMT=0):
  - S<=F for HSEL 000 or AMT=0; S<=0 for HSEL 011.
  - CO<=0, except AMT=0 with HSEL 100/111 gives CO<=CI.
  - DONE<=1 at edge k. BUSY stays 0.
- RUN: edges k+1..k+AMT each perform one step; count decrements.
  - At edge k+AMT: BUSY<=0, DONE<=1.
  - DONE clears on the following edge unless a new single-cycle START is accepted there.
- Step definitions (W=WIDTH):
  - 001 shift left: S<={S[W-2:0],0}; CO<=S[W-1]
  - 010 shift right: S<={0,S[W-1:1]}; CO<=S[0]
  - 100 rotate left through carry: S<={S[W-2:0],CO}; CO<=S[W-1]
  - 101 rotate left: S<={S[W-2:0],S[W-1]}; CO<=S[W-1]
  - 110 rotate right: S<={S[0],S[W-1:1]}; CO<=S[0]
  - 111 rotate right through carry: S<={CO,S[W-1:1]}; CO<=S[0]
- AMT is not clamped; exactly AMT steps are performed.
  - Rotates have period W; through-carry rotates have period W+1.
  - Shifts with AMT>=W yield S=0.
- During RUN, S/CO show intermediate values; consumers use them only when DONE=1.
- S/CO hold their final values until the next accepted START or RESET.
- START while BUSY=1 is ignored. F/CI/HSEL/AMT changes during RUN have no effect.
- START on the same edge as the final step (BUSY still 1) is ignored.
- START and RESET on the same edge: RESET wins.
- Throughput: back-to-back operations need START re-asserted once BUSY=0.

Test Plan:
- WIDTH=8, HSEL=001, F=0x81, AMT=1 -> edge k+1: S=0x02, CO=1, DONE=1 for one cycle, BUSY high for exactly 1 cycle.
- HSEL=100, F=0x80, CI=0, AMT=9 -> BUSY high 9 cycles; at DONE S=0x80, CO=0 (full through-carry period).
- HSEL=110, F=0x01, AMT=3 -> S=0x20, CO=0. Also HSEL=111, F=0x01, CI=1, AMT=2 -> S=0xC0, CO=0.
- HSEL=000, F=0x5A, AMT=7 -> DONE at edge k, S=0x5A, CO=0, BUSY never 1. Then HSEL=011 -> S=0x00. Then HSEL=101, AMT=0, F=0x3C -> S=0x3C, DONE at edge k.
- HSEL=101, F=0x0F, AMT=4; pulse START with F=0xFF, HSEL=011 at edge k+2 -> second START ignored; final S=0xF0, CO=0, exactly one DONE.
- HSEL=010, F=0xFF, AMT=5; assert RESET at edge k+2 -> S=0, CO=0, BUSY=0, no DONE afterward. A new START next cycle with HSEL=010, F=0xFF, AMT=10 -> S=0x00, CO=0, BUSY high 10 cycles.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate unit, one 1-bit step per clock; in: CLK RESET START F CI HSEL AMT, out: S CO BUSY DONE
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] F,
  input  logic             CI,
  input  logic [2:0]       HSEL,
  input  logic [AMTW-1:0]  AMT,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             BUSY,
  output logic             DONE
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q;
  logic [WIDTH-1:0] s_q, s_d;
  logic co_q, co_d, busy_q, done_q, thru, multi, left, in_bit;
  logic [2:0] hsel_q;
  logic [AMTW-1:0] cnt_q;
  always_comb begin
    thru   = HSEL == 3'b100 || HSEL == 3'b111;
    multi  = AMT != '0 && HSEL != 3'b000 && HSEL != 3'b011;
    left   = hsel_q == 3'b001 || hsel_q == 3'b100 || hsel_q == 3'b101;
    in_bit = (hsel_q == 3'b100 || hsel_q == 3'b111) ? co_q :
             hsel_q == 3'b101 ? s_q[WIDTH-1] :
             hsel_q == 3'b110 ? s_q[0] : 1'b0;
    s_d    = left ? {s_q[WIDTH-2:0], in_bit} : {in_bit, s_q[WIDTH-1:1]};
    co_d   = left ? s_q[WIDTH-1] : s_q[0];
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      hsel_q  <= '0;
    end else if (state_q == IDLE) begin
      done_q <= 1'b0;
      if (START) begin
        hsel_q <= HSEL;
        if (multi) begin
          s_q     <= F;
          co_q    <= thru & CI;
          cnt_q   <= AMT;
          busy_q  <= 1'b1;
          state_q <= RUN;
        end else begin
          s_q    <= (HSEL == 3'b011 && AMT != '0) ? '0 : F;
          co_q   <= thru & CI;
          done_q <= 1'b1;
        end
      end
    end else begin
      s_q   <= s_d;
      co_q  <= co_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == AMTW'(1)) begin
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        state_q <= IDLE;
      end
    end
  end
  assign S    = s_q;
  assign CO   = co_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: randomized and directed checks of seq_shifter against an arithmetic reference model
module tb_seq_shifter;
  logic clk, RESET, START, CI, CO, BUSY, DONE;
  logic [7:0] F, S;
  logic [2:0] HSEL;
  logic [3:0] AMT;
  int n_tests = 0, n_fail = 0, done_cnt = 0;

  seq_shifter #(.WIDTH(8), .AMTW(4)) dut (
    .CLK(clk), .RESET(RESET), .START(START), .F(F), .CI(CI), .HSEL(HSEL), .AMT(AMT),
    .S(S), .CO(CO), .BUSY(BUSY), .DONE(DONE)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (DONE) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [7:0] f, input logic ci, input logic [2:0] h, input int a,
                                output logic [7:0] s, output logic c, output int cyc);
    logic [15:0] t;
    logic [17:0] u;
    logic [8:0] v;
    cyc = (a == 0 || h == 3'd0 || h == 3'd3) ? 0 : a;
    s = f;
    c = 1'b0;
    if (a == 0) begin
      c = (h == 3'd4 || h == 3'd7) ? ci : 1'b0;
      return;
    end
    v = {ci, f};
    case (h)
      3'd3: s = 8'h00;
      3'd1: begin t = {8'h00, f} << a; s = t[7:0]; c = t[8]; end
      3'd2: begin t = {f, 8'h00} >> a; s = t[15:8]; c = t[7]; end
      3'd5: begin t = {f, f} << (a % 8); s = t[15:8]; c = s[0]; end
      3'd6: begin t = {f, f} >> (a % 8); s = t[7:0]; c = s[7]; end
      3'd4: begin u = {v, v} << (a % 9); v = u[17:9]; s = v[7:0]; c = v[8]; end
      3'd7: begin u = {v, v} >> (a % 9); v = u[8:0]; s = v[7:0]; c = v[8]; end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [7:0] f, input logic ci, input logic [2:0] h, input int a);
    logic [7:0] es;
    logic ec;
    int ecyc, busy_n, t;
    model(f, ci, h, a, es, ec, ecyc);
    @(negedge clk);
    START = 1; F = f; CI = ci; HSEL = h; AMT = 4'(a);
    @(negedge clk);
    START = 0; F = 8'($urandom); CI = 1'($urandom); HSEL = 3'($urandom); AMT = 4'($urandom);
    busy_n = 0;
    t = 0;
    while (!DONE && t < 40) begin
      if (BUSY) busy_n++;
      @(negedge clk);
      t++;
    end
    chk($sformatf("done_seen h=%0d a=%0d", h, a), 32'(DONE), 1);
    chk($sformatf("busy_cycles h=%0d a=%0d", h, a), busy_n, ecyc);
    chk($sformatf("s h=%0d f=%0h a=%0d", h, f, a), 32'(S), 32'(es));
    chk($sformatf("co h=%0d f=%0h a=%0d", h, f, a), 32'(CO), 32'(ec));
    @(negedge clk);
    chk("done_pulse", 32'(DONE), 0);
    chk("hold_s", 32'(S), 32'(es));
  endtask

  initial begin
    int d0, t;
    RESET = 1; START = 0; F = 0; CI = 0; HSEL = 0; AMT = 0;
    repeat (3) @(negedge clk);
    chk("rst_s", 32'(S), 0);
    chk("rst_co", 32'(CO), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    RESET = 0;

    run_op(8'h81, 0, 3'b001, 1);
    run_op(8'h80, 0, 3'b100, 9);
    run_op(8'h01, 0, 3'b110, 3);
    run_op(8'h01, 1, 3'b111, 2);
    run_op(8'h5A, 1, 3'b000, 7);
    run_op(8'h5A, 1, 3'b011, 7);
    run_op(8'h3C, 1, 3'b101, 0);
    run_op(8'h3C, 1, 3'b100, 0);
    run_op(8'hFF, 0, 3'b001, 15);

    // START held from k+2 through the final step must be ignored
    d0 = done_cnt;
    @(negedge clk);
    START = 1; F = 8'h0F; CI = 0; HSEL = 3'b101; AMT = 4;
    @(negedge clk);
    START = 0;
    @(negedge clk);
    START = 1; F = 8'hFF; HSEL = 3'b011;
    t = 0;
    while (!DONE && t < 20) begin @(negedge clk); t++; end
    START = 0;
    chk("ign_done", 32'(DONE), 1);
    chk("ign_s", 32'(S), 32'h F0);
    chk("ign_co", 32'(CO), 0);
    @(negedge clk);
    chk("ign_done_cnt", done_cnt - d0, 1);
    chk("ign_busy", 32'(BUSY), 0);

    // reset mid-operation aborts without DONE
    d0 = done_cnt;
    @(negedge clk);
    START = 1; F = 8'hFF; CI = 0; HSEL = 3'b010; AMT = 5;
    @(negedge clk);
    START = 0;
    @(negedge clk);
    RESET = 1;
    @(negedge clk);
    RESET = 0;
    chk("abort_s", 32'(S), 0);
    chk("abort_co", 32'(CO), 0);
    chk("abort_busy", 32'(BUSY), 0);
    chk("abort_done", 32'(DONE), 0);
    repeat (2) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run_op(8'hFF, 0, 3'b010, 10);

    // RESET wins over START on the same edge
    @(negedge clk);
    RESET = 1; START = 1; F = 8'hAA; HSEL = 3'b000; AMT = 0;
    @(negedge clk);
    RESET = 0; START = 0;
    chk("rst_start_s", 32'(S), 0);
    chk("rst_start_done", 32'(DONE), 0);

    for (int i = 0; i < 40; i++)
      run_op(8'($urandom), 1'($urandom), 3'($urandom), int'($urandom_range(0, 15)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
